// File: rtl/sample_packetizer.sv
// ============================================================================
//  Module      : sample_packetizer
//  Description : Buffers 16-bit ADC samples in a circular FIFO and frames them
//                into header/sequence/sample byte packets for the FX2 port.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sample_packetizer #(
    parameter int         DEPTH_LOG2  = 4,
    parameter int         PKT_SAMPLES = 8,
    parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
    input  logic                  FX2_CLK,
    input  logic                  RST,
    input  logic [15:0]           SAMPLE_IN,
    input  logic                  SAMPLE_VALID,
    input  logic [7:0]            PCINSTRUCTION,
    output logic [7:0]            FPGA_WORD,
    output logic                  FPGA_WORD_AVAILIABLE,
    input  logic                  FPGA_WORD_ACCEPTED,
    output logic                  RUNNING,
    output logic                  OVERFLOW,
    output logic [DEPTH_LOG2:0]   FILL_LEVEL
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_KL    = PKT_SAMPLES - 1;

    localparam logic [DEPTH_LOG2:0]   c_DEPTH_CNT = c_DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   c_PKT_CNT   = PKT_SAMPLES[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   c_CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_K_LAST    = c_KL[DEPTH_LOG2-1:0];

    localparam logic [7:0] c_CMD_START = 8'h01;
    localparam logic [7:0] c_CMD_STOP  = 8'h02;
    localparam logic [7:0] c_CMD_FLUSH = 8'h03;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_HDR  = 3'd1;
    localparam logic [2:0] c_ST_SEQ  = 3'd2;
    localparam logic [2:0] c_ST_HI   = 3'd3;
    localparam logic [2:0] c_ST_LO   = 3'd4;

    logic [15:0]           r_mem [0:c_DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_running;
    logic                  r_overflow;
    logic [7:0]            r_seq;
    logic [DEPTH_LOG2-1:0] r_k;
    logic [2:0]            r_state;
    logic [2:0]            w_next;

    logic        w_start;
    logic        w_stop;
    logic        w_flush;
    logic        w_xfer;
    logic        w_full;
    logic        w_req;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [15:0] w_head;

    assign w_start = (PCINSTRUCTION == c_CMD_START);
    assign w_stop  = (PCINSTRUCTION == c_CMD_STOP);
    assign w_flush = (PCINSTRUCTION == c_CMD_FLUSH);
    assign w_xfer  = FPGA_WORD_AVAILIABLE && FPGA_WORD_ACCEPTED;
    assign w_full  = (r_count == c_DEPTH_CNT);
    assign w_head  = r_mem[r_rptr];

    // A pop on the same edge frees the slot, so a push into a full FIFO is legal then.
    assign w_req  = SAMPLE_VALID && r_running && !w_flush;
    assign w_pop  = w_xfer && (r_state == c_ST_LO) && !w_flush;
    assign w_push = w_req && (!w_full || w_pop);
    assign w_drop = w_req && w_full && !w_pop;

    always_ff @(posedge FX2_CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= SAMPLE_IN;
        end
    end

    always_ff @(posedge FX2_CLK) begin
        if (RST) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
            r_seq      <= 8'h00;
            r_k        <= '0;
        end else if (w_flush) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
            r_seq      <= 8'h00;
            r_k        <= '0;
        end else begin
            if (w_start) begin
                r_running <= 1'b1;
            end else if (w_stop) begin
                r_running <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_start) begin
                r_overflow <= 1'b0;
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
            if (w_xfer && (r_state == c_ST_SEQ)) begin
                r_seq <= r_seq + 8'd1;
                r_k   <= '0;
            end
            if (w_xfer && (r_state == c_ST_LO) && (r_k != c_K_LAST)) begin
                r_k <= r_k + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge FX2_CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: if (r_count >= c_PKT_CNT) w_next = c_ST_HDR;
            c_ST_HDR:  if (w_xfer) w_next = c_ST_SEQ;
            c_ST_SEQ:  if (w_xfer) w_next = c_ST_HI;
            c_ST_HI:   if (w_xfer) w_next = c_ST_LO;
            c_ST_LO:   if (w_xfer) w_next = (r_k == c_K_LAST) ? c_ST_IDLE : c_ST_HI;
            default:   w_next = c_ST_IDLE;
        endcase
        if (w_flush) begin
            w_next = c_ST_IDLE;
        end
    end

    always_comb begin
        FPGA_WORD_AVAILIABLE = 1'b0;
        FPGA_WORD            = 8'h00;
        case (r_state)
            c_ST_HDR: begin
                FPGA_WORD_AVAILIABLE = 1'b1;
                FPGA_WORD            = HDR_BYTE;
            end
            c_ST_SEQ: begin
                FPGA_WORD_AVAILIABLE = 1'b1;
                FPGA_WORD            = r_seq;
            end
            c_ST_HI: begin
                FPGA_WORD_AVAILIABLE = 1'b1;
                FPGA_WORD            = w_head[15:8];
            end
            c_ST_LO: begin
                FPGA_WORD_AVAILIABLE = 1'b1;
                FPGA_WORD            = w_head[7:0];
            end
            default: begin
                FPGA_WORD_AVAILIABLE = 1'b0;
                FPGA_WORD            = 8'h00;
            end
        endcase
    end

    assign RUNNING    = r_running;
    assign OVERFLOW   = r_overflow;
    assign FILL_LEVEL = r_count;

endmodule

`default_nettype wire

// File: tb/tb_sample_packetizer.sv
// ============================================================================
//  Module      : tb_sample_packetizer
//  Description : Directed, scoreboard-checked bench for sample_packetizer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sample_packetizer;

    logic        clk;
    logic        rst;
    logic [15:0] sample;
    logic        valid;
    logic [7:0]  instr;
    logic        accepted;
    logic [7:0]  word;
    logic        avail;
    logic        running;
    logic        overflow;
    logic [4:0]  fill;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;

    logic [7:0]  q_exp[$];
    logic [15:0] m_samp[$];
    logic [7:0]  m_seq = 8'h00;
    logic        hold_pending = 1'b0;
    logic [7:0]  held_word = 8'h00;

    sample_packetizer #(
        .DEPTH_LOG2 (4),
        .PKT_SAMPLES(8),
        .HDR_BYTE   (8'hA5)
    ) dut (
        .FX2_CLK             (clk),
        .RST                 (rst),
        .SAMPLE_IN           (sample),
        .SAMPLE_VALID        (valid),
        .PCINSTRUCTION       (instr),
        .FPGA_WORD           (word),
        .FPGA_WORD_AVAILIABLE(avail),
        .FPGA_WORD_ACCEPTED  (accepted),
        .RUNNING             (running),
        .OVERFLOW            (overflow),
        .FILL_LEVEL          (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model FIFO: every PKT_SAMPLES accepted samples become one expected packet.
    task automatic add_sample(input logic [15:0] s);
        logic [15:0] t;
        m_samp.push_back(s);
        if (m_samp.size() == 8) begin
            q_exp.push_back(8'hA5);
            q_exp.push_back(m_seq);
            m_seq = m_seq + 8'd1;
            for (int i = 0; i < 8; i++) begin
                t = m_samp[i];
                q_exp.push_back(t[15:8]);
                q_exp.push_back(t[7:0]);
            end
            m_samp.delete();
        end
    endtask

    // Checks the byte about to transfer and hold stability, then advances one edge.
    task automatic tick();
        logic [7:0] e;
        if (hold_pending) begin
            chk("hold_avail", {31'h0, avail}, 32'h1);
            chk("hold_word", {24'h0, word}, {24'h0, held_word});
        end
        if (avail === 1'b1 && accepted === 1'b1) begin
            n_checks++;
            assert (q_exp.size() != 0) else begin
                n_errors++;
                $error("FAIL sb_underflow: observed byte %02h, expected none", word);
            end
            if (q_exp.size() != 0) begin
                e = q_exp.pop_front();
                chk("byte", {24'h0, word}, {24'h0, e});
            end
            n_xfer++;
        end
        hold_pending = (avail === 1'b1) && !accepted && (instr != 8'h03) && !rst;
        held_word    = word;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while (q_exp.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        assert (q_exp.size() == 0) else begin
            n_errors++;
            $error("FAIL %s_timeout: observed %0d pending bytes, expected 0", tag, q_exp.size());
        end
        repeat (3) tick();
    endtask

    task automatic command(input logic [7:0] c);
        instr = c;
        tick();
        instr = 8'h00;
    endtask

    initial begin
        int n;
        int pos;
        int n_pushed;
        int n_fullpush;
        logic lo_next;
        logic at_full;

        rst = 1'b1; sample = 16'h0; valid = 1'b0; instr = 8'h00; accepted = 1'b0;
        repeat (3) tick();
        hold_pending = 1'b0;
        chk("rst_word", {24'h0, word}, 32'h0);
        chk("rst_avail", {31'h0, avail}, 32'h0);
        chk("rst_running", {31'h0, running}, 32'h0);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_fill", {27'h0, fill}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic packet, latency of HDR, and a second packet with sequence 01.
        instr = 8'h01; tick(); tick(); instr = 8'h00;
        chk("start_running", {31'h0, running}, 32'h1);
        command(8'h7F);
        chk("ignored_cmd", {31'h0, running}, 32'h1);
        accepted = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; sample = 16'h1000 + 16'(i); add_sample(sample); tick();
        end
        valid = 1'b0;
        chk("lat_idle_avail", {31'h0, avail}, 32'h0);
        chk("lat_fill8", {27'h0, fill}, 32'd8);
        tick();
        chk("lat_hdr_avail", {31'h0, avail}, 32'h1);
        chk("lat_hdr_word", {24'h0, word}, 32'hA5);
        drain(100, "pkt0");
        chk("pkt0_fill", {27'h0, fill}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; sample = 16'h2000 + 16'(i); add_sample(sample); tick();
        end
        valid = 1'b0;
        drain(100, "pkt1");
        chk("pkt1_avail_idle", {31'h0, avail}, 32'h0);

        // Back-pressure with ACCEPTED toggling.
        accepted = 1'b0;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; sample = 16'h3000 + 16'(i); add_sample(sample); tick();
        end
        valid = 1'b0;
        n = 0;
        while (q_exp.size() != 0 && n < 200) begin
            accepted = n[0];
            tick();
            n++;
        end
        accepted = 1'b1;
        drain(10, "toggle");

        // Overflow: 20 samples into a 16-deep FIFO with no draining.
        accepted = 1'b0;
        for (int i = 0; i < 20; i++) begin
            valid = 1'b1; sample = 16'h4000 + 16'(i);
            if (i < 16) add_sample(sample);
            tick();
        end
        valid = 1'b0;
        chk("ovf_fill", {27'h0, fill}, 32'd16);
        chk("ovf_flag", {31'h0, overflow}, 32'h1);
        accepted = 1'b1;
        drain(200, "ovf");
        chk("ovf_sticky", {31'h0, overflow}, 32'h1);
        chk("ovf_drained", {27'h0, fill}, 32'h0);
        command(8'h01);
        chk("ovf_start_clear", {31'h0, overflow}, 32'h0);

        // STOP after the HI byte of the third sample; later samples are ignored.
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; sample = 16'h5000 + 16'(i); add_sample(sample); tick();
        end
        valid = 1'b0;
        n = 0;
        while (q_exp.size() > 11 && n < 100) begin
            tick();
            n++;
        end
        command(8'h02);
        chk("stop_running", {31'h0, running}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1; sample = 16'h5100 + 16'(i); tick();
        end
        valid = 1'b0;
        drain(100, "stop");
        chk("stop_fill", {27'h0, fill}, 32'h0);
        chk("stop_idle", {31'h0, avail}, 32'h0);

        // FLUSH mid-packet with 12 samples buffered and a concurrent sample.
        command(8'h01);
        accepted = 1'b0;
        for (int i = 0; i < 12; i++) begin
            valid = 1'b1; sample = 16'h6000 + 16'(i); tick();
        end
        valid = 1'b0;
        q_exp.push_back(8'hA5);
        q_exp.push_back(m_seq);
        q_exp.push_back(8'h60);
        q_exp.push_back(8'h00);
        accepted = 1'b1;
        n = 0;
        while (q_exp.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        accepted = 1'b0;
        chk("flush_pre_fill", {27'h0, fill}, 32'd11);
        valid = 1'b1; sample = 16'hDEAD; instr = 8'h03;
        tick();
        valid = 1'b0; instr = 8'h00;
        chk("flush_avail", {31'h0, avail}, 32'h0);
        chk("flush_fill", {27'h0, fill}, 32'h0);
        chk("flush_running", {31'h0, running}, 32'h0);
        tick();
        chk("flush_fill_hold", {27'h0, fill}, 32'h0);
        m_seq = 8'h00;
        command(8'h01);
        accepted = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; sample = 16'h7000 + 16'(i); add_sample(sample); tick();
        end
        valid = 1'b0;
        drain(100, "post_flush");

        // 256 more packets: sequence wraps FF->00, with pushes at full timed onto pops.
        n_pushed = 0; n_fullpush = 0; n = 0;
        pos = n_xfer;
        while ((n_pushed < 2048 || q_exp.size() != 0) && n < 20000) begin
            lo_next = (avail === 1'b1) && (((n_xfer - pos) % 18) >= 3) && (((n_xfer - pos) % 2) == 1);
            at_full = (fill == 5'd16);
            valid = (n_pushed < 2048) && (!at_full || lo_next);
            if (valid) begin
                sample = 16'(n_pushed * 7 + 3);
                add_sample(sample);
                n_pushed++;
            end
            tick();
            if (valid && at_full) begin
                chk("full_pushpop_fill", {27'h0, fill}, 32'd16);
                n_fullpush++;
            end
            n++;
        end
        valid = 1'b0;
        chk("wrap_done", {31'h0, (q_exp.size() == 0)}, 32'h1);
        chk("wrap_fullpush_seen", {31'h0, (n_fullpush != 0)}, 32'h1);
        chk("wrap_no_overflow", {31'h0, overflow}, 32'h0);
        repeat (3) tick();
        chk("wrap_fill", {27'h0, fill}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sample_packetizer.md
Name: sample_packetizer

Overview:
- Sits directly upstream of the FX2 bidirectional FIFO interface.
- Buffers 16-bit ADC samples in a small circular FIFO and frames them into fixed-length byte packets: header, sequence number, then sample bytes, high byte first.
- Drives the FPGA_WORD / FPGA_WORD_AVAILIABLE / FPGA_WORD_ACCEPTED byte handshake.
- Decodes host command bytes arriving on PCINSTRUCTION to start, stop and flush acquisition.

Parameters:
- DEPTH_LOG2, 4: sample FIFO depth = 2^DEPTH_LOG2 entries of 16 bits.
- PKT_SAMPLES, 8: samples per packet; legal range 1..2^DEPTH_LOG2.
- HDR_BYTE, 8'hA5: first byte of every packet.

Ports:
- FX2_CLK  in  1  system clock, same clock as the FX2 interface.
- RST  in  1  synchronous, active-high reset.
- SAMPLE_IN  in  16  ADC sample.
- SAMPLE_VALID  in  1  SAMPLE_IN valid this cycle.
- PCINSTRUCTION  in  8  host command byte; 8'h00 = no command.
- FPGA_WORD  out  8  byte offered to the FX2 interface.
- FPGA_WORD_AVAILIABLE  out  1  FPGA_WORD valid.
- FPGA_WORD_ACCEPTED  in  1  byte consumed this cycle; may be combinational from AVAILIABLE.
- RUNNING  out  1  acquisition enabled.
- OVERFLOW  out  1  sticky: a sample was dropped because the FIFO was full.
- FILL_LEVEL  out  DEPTH_LOG2+1  current FIFO occupancy.

Behaviour:
- Reset: every output 0, FSM in IDLE, FIFO pointers and count 0, sequence counter 0. Reset has priority over all other events, including mid-packet.
- Transfer definition: a byte transfers on a rising edge where FPGA_WORD_AVAILIABLE && FPGA_WORD_ACCEPTED. AVAILIABLE never drops while a byte is pending, except on FLUSH or reset.
- Commands are sampled on every edge:
  - 8'h01 START: RUNNING <= 1 and OVERFLOW <= 0.
  - 8'h02 STOP: RUNNING <= 0.
  - 8'h03 FLUSH: RUNNING <= 0, FIFO emptied, OVERFLOW <= 0, sequence <= 0, FSM forced to IDLE (any packet in progress is aborted).
  - Any other nonzero value is ignored. A command repeated on consecutive cycles is idempotent.
- FIFO push: SAMPLE_VALID && RUNNING && count < 2^DEPTH_LOG2.
  - If SAMPLE_VALID && RUNNING arrives while full, the sample is dropped and OVERFLOW <= 1; it stays set until START, FLUSH or RST.
  - When SAMPLE_VALID && RUNNING coincide with FLUSH, FLUSH wins and no sample is written.
- FIFO pop: on transfer of an LO byte.
  - Push and pop on the same edge leave the count unchanged, and are legal when full.
  - Pointers wrap modulo 2^DEPTH_LOG2.
- FILL_LEVEL equals the registered count.
- FSM states: IDLE, HDR, SEQ, HI, LO, with sample index k counting 0..PKT_SAMPLES-1.
  - IDLE: AVAILIABLE=0, FPGA_WORD=8'h00. Go to HDR on the next edge if count >= PKT_SAMPLES. Because a packet starts only when fully buffered, it never stalls for data.
  - HDR: FPGA_WORD=HDR_BYTE; on transfer go to SEQ.
  - SEQ: FPGA_WORD=sequence; on transfer go to HI with k=0, and increment sequence (8-bit, wraps 255->0).
  - HI: FPGA_WORD=FIFO head[15:8]; on transfer go to LO.
  - LO: FPGA_WORD=FIFO head[7:0]; on transfer pop. If k=PKT_SAMPLES-1 go to IDLE, else go to HI with k+1.
- Timing: at least one IDLE bubble between packets. A packet is 2+2*PKT_SAMPLES bytes.
- Latency: the PKT_SAMPLES-th sample pushed at edge N puts the FSM in IDLE with count>=PKT_SAMPLES after N. HDR is presented after edge N+1.
- STOP mid-packet: the current packet completes, and further full packets already buffered still drain. A partial remainder (< PKT_SAMPLES) stays in the FIFO until FLUSH or until more samples arrive.
- Outputs FPGA_WORD and AVAILIABLE are decoded from registered state and the FIFO head only, with no combinational path from FPGA_WORD_ACCEPTED.

Test Plan:
- Reset then START, push 8 samples 16'h1000..16'h1007 on consecutive cycles, ACCEPTED held 1 -> bytes A5,00,10,00,10,01,...,10,07. FILL_LEVEL returns to 0. A second packet carries sequence 01.
- ACCEPTED toggling 1,0,1,0 during a packet -> each byte held stable while ACCEPTED=0. No byte is skipped or duplicated, and the 18-byte order is unchanged.
- With RUNNING=1 and ACCEPTED=0, push 20 samples into a depth-16 FIFO -> FILL_LEVEL=16 and OVERFLOW=1. The first 16 samples are delivered intact; samples 17-20 are absent.
- Issue STOP after the HI byte of sample 3, then push 5 more samples -> the packet completes with 8 samples, no new samples are stored, and the FSM stays IDLE with FILL_LEVEL=0.
- Issue FLUSH mid-packet with 12 samples buffered -> AVAILIABLE=0 on the next cycle, FILL_LEVEL=0 and RUNNING=0. After START, the next packet has sequence 00.
- Run 257 packets -> the sequence byte wraps FF->00. Simultaneous push/pop at full keeps FILL_LEVEL=16 with no OVERFLOW.
